// File: rtl/cas_mem_arb_if.sv
// Bus bundle between the cassette memory arbiter, the image loader, the
// cassette reader and the memory controller. slave = arbiter view.
interface cas_mem_arb_if;
   logic        dl_wr;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic        dl_wait;
   logic        cas_rd;
   logic [24:0] cas_addr;
   logic [7:0]  cas_data;
   logic        cas_valid;
   logic [24:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we;
   logic        mem_rd;
   logic        mem_ack;
   logic [7:0]  mem_dout;
   logic        err;

   modport slave (
      input  dl_wr, dl_addr, dl_data, cas_rd, cas_addr, mem_ack, mem_dout,
      output dl_wait, cas_data, cas_valid, mem_addr, mem_din, mem_we, mem_rd, err
   );

   modport master (
      output dl_wr, dl_addr, dl_data, cas_rd, cas_addr, mem_ack, mem_dout,
      input  dl_wait, cas_data, cas_valid, mem_addr, mem_din, mem_we, mem_rd, err
   );
endinterface

// File: rtl/cas_mem_arb.sv
// Arbitrates a one-entry download write buffer and cassette byte reads onto one
// memory port. Define CAS_ARB_TIMEOUT_EN to abort accesses lacking mem_ack.
module cas_mem_arb (
   input  logic         clk,
   input  logic         reset,
   cas_mem_arb_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

   state_t      state_q;
   logic        cas_rd_q;
   logic        buf_full_q;
   logic [24:0] buf_addr_q;
   logic [7:0]  buf_data_q;
   logic        pend_q;
   logic [24:0] pend_addr_q;
   logic [7:0]  cas_data_q;
   logic        cas_valid_q;
   logic [24:0] mem_addr_q;
   logic [7:0]  mem_din_q;
   logic        mem_we_q;
   logic        mem_rd_q;
   logic        err_q;
`ifdef CAS_ARB_TIMEOUT_EN
   logic [7:0]  tmo_q;
`endif

   logic cas_edge_d;
   logic dl_take_d;

   assign cas_edge_d = bus.cas_rd & ~cas_rd_q;
   assign dl_take_d  = bus.dl_wr & ~buf_full_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         // Track the live level so a cas_rd held through reset is not an edge.
         cas_rd_q    <= bus.cas_rd;
         buf_full_q  <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         cas_data_q  <= '0;
         cas_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         mem_we_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         err_q       <= 1'b0;
`ifdef CAS_ARB_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         cas_rd_q    <= bus.cas_rd;
         cas_valid_q <= 1'b0;

         if (dl_take_d) begin
            buf_full_q <= 1'b1;
            buf_addr_q <= bus.dl_addr;
            buf_data_q <= bus.dl_data;
         end
         if (bus.dl_wr && buf_full_q)
            err_q <= 1'b1;

         if (cas_edge_d) begin
            pend_q      <= 1'b1;
            pend_addr_q <= bus.cas_addr;
         end

         case (state_q)
            S_IDLE: begin
`ifdef CAS_ARB_TIMEOUT_EN
               tmo_q <= '0;
`endif
               // A strobe this cycle is forwarded straight to the memory port.
               if (buf_full_q || dl_take_d) begin
                  state_q    <= S_WRITE;
                  mem_we_q   <= 1'b1;
                  mem_addr_q <= buf_full_q ? buf_addr_q : bus.dl_addr;
                  mem_din_q  <= buf_full_q ? buf_data_q : bus.dl_data;
               end else if (pend_q) begin
                  state_q    <= S_READ;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= pend_addr_q;
                  if (!cas_edge_d)
                     pend_q <= 1'b0;
               end
            end

            S_WRITE: begin
               if (bus.mem_ack) begin
                  state_q    <= S_IDLE;
                  mem_we_q   <= 1'b0;
                  buf_full_q <= 1'b0;
               end
`ifdef CAS_ARB_TIMEOUT_EN
               else if (tmo_q == 8'd254) begin
                  state_q    <= S_IDLE;
                  mem_we_q   <= 1'b0;
                  buf_full_q <= 1'b0;
                  err_q      <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
`endif
            end

            S_READ: begin
               if (bus.mem_ack) begin
                  state_q     <= S_IDLE;
                  mem_rd_q    <= 1'b0;
                  cas_data_q  <= bus.mem_dout;
                  cas_valid_q <= 1'b1;
               end
`ifdef CAS_ARB_TIMEOUT_EN
               else if (tmo_q == 8'd254) begin
                  state_q     <= S_IDLE;
                  mem_rd_q    <= 1'b0;
                  cas_data_q  <= 8'hFF;
                  cas_valid_q <= 1'b1;
                  err_q       <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
`endif
            end

            default: begin
               state_q  <= S_IDLE;
               mem_we_q <= 1'b0;
               mem_rd_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dl_wait   = buf_full_q;
   assign bus.cas_data  = cas_data_q;
   assign bus.cas_valid = cas_valid_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_din   = mem_din_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_cas_mem_arb.sv
// Directed bench for cas_mem_arb: write, read, priority, overflow, reset and
// (when CAS_ARB_TIMEOUT_EN is defined) read timeout scenarios.
module tb_cas_mem_arb;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   overlap_cnt;
   int   valid_cnt;
   int   wr_cnt;
   int   we_cnt;
   int   base_v;
   int   base_w;
   int   base_we;

   cas_mem_arb_if bus ();

   cas_mem_arb u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      overlap_cnt = 0;
      valid_cnt   = 0;
      wr_cnt      = 0;
      we_cnt      = 0;
   end

   always @(negedge clk) begin
      if (bus.mem_we && bus.mem_rd) overlap_cnt = overlap_cnt + 1;
      if (bus.cas_valid)            valid_cnt   = valid_cnt + 1;
      if (bus.mem_we && bus.mem_ack) wr_cnt     = wr_cnt + 1;
      if (bus.mem_we)               we_cnt      = we_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
      bus.cas_rd = 1'b0; bus.cas_addr = '0;
      bus.mem_ack = 1'b0; bus.mem_dout = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_dl_wait", 32'(bus.dl_wait), 32'h0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
      chk("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      chk("rst_cas_valid", 32'(bus.cas_valid), 32'h0);
      chk("rst_cas_data", 32'(bus.cas_data), 32'h0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst_mem_din", 32'(bus.mem_din), 32'h0);
      $display("txn reset released");

      // Single download write, ack three cycles after the strobe
      bus.dl_wr = 1'b1; bus.dl_addr = 25'h10; bus.dl_data = 8'h55;
      tick();
      bus.dl_wr = 1'b0;
      chk("w1_mem_we", 32'(bus.mem_we), 32'h1);
      chk("w1_mem_addr", 32'(bus.mem_addr), 32'h10);
      chk("w1_mem_din", 32'(bus.mem_din), 32'h55);
      chk("w1_dl_wait", 32'(bus.dl_wait), 32'h1);
      chk("w1_mem_rd", 32'(bus.mem_rd), 32'h0);
      tick();
      tick();
      chk("w1_we_held", 32'(bus.mem_we), 32'h1);
      chk("w1_addr_held", 32'(bus.mem_addr), 32'h10);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("w1_we_after_ack", 32'(bus.mem_we), 32'h0);
      chk("w1_wait_after_ack", 32'(bus.dl_wait), 32'h0);
      $display("txn write addr=10 din=55 done");

      // Single cassette read
      base_v = valid_cnt; base_we = we_cnt;
      bus.cas_rd = 1'b1; bus.cas_addr = 25'h33;
      tick();
      bus.cas_rd = 1'b0;
      tick();
      chk("r1_mem_rd", 32'(bus.mem_rd), 32'h1);
      chk("r1_mem_addr", 32'(bus.mem_addr), 32'h33);
      bus.mem_ack = 1'b1; bus.mem_dout = 8'hA5;
      tick();
      bus.mem_ack = 1'b0; bus.mem_dout = 8'h00;
      chk("r1_cas_valid", 32'(bus.cas_valid), 32'h1);
      chk("r1_cas_data", 32'(bus.cas_data), 32'hA5);
      chk("r1_mem_rd_off", 32'(bus.mem_rd), 32'h0);
      tick();
      chk("r1_valid_drop", 32'(bus.cas_valid), 32'h0);
      chk("r1_data_held", 32'(bus.cas_data), 32'hA5);
      chk("r1_valid_pulses", 32'(valid_cnt - base_v), 32'h1);
      chk("r1_we_never", 32'(we_cnt - base_we), 32'h0);
      $display("txn read addr=33 data=a5 done");

      // Simultaneous write and read request: write wins
      bus.dl_wr = 1'b1; bus.dl_addr = 25'h20; bus.dl_data = 8'h66;
      bus.cas_rd = 1'b1; bus.cas_addr = 25'h44;
      tick();
      bus.dl_wr = 1'b0; bus.cas_rd = 1'b0;
      chk("p_we_first", 32'(bus.mem_we), 32'h1);
      chk("p_rd_not_yet", 32'(bus.mem_rd), 32'h0);
      chk("p_w_addr", 32'(bus.mem_addr), 32'h20);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("p_idle_we", 32'(bus.mem_we), 32'h0);
      chk("p_idle_rd", 32'(bus.mem_rd), 32'h0);
      tick();
      chk("p_rd_after", 32'(bus.mem_rd), 32'h1);
      chk("p_r_addr", 32'(bus.mem_addr), 32'h44);
      bus.mem_ack = 1'b1; bus.mem_dout = 8'h77;
      tick();
      bus.mem_ack = 1'b0;
      chk("p_cas_data", 32'(bus.cas_data), 32'h77);
      chk("p_cas_valid", 32'(bus.cas_valid), 32'h1);
      $display("txn write addr=20 then read addr=44 done");

      // Download strobe during a read waits for the read to finish
      bus.cas_rd = 1'b1; bus.cas_addr = 25'h60;
      tick();
      bus.cas_rd = 1'b0;
      tick();
      chk("np_rd", 32'(bus.mem_rd), 32'h1);
      bus.dl_wr = 1'b1; bus.dl_addr = 25'h40; bus.dl_data = 8'h99;
      tick();
      bus.dl_wr = 1'b0;
      chk("np_no_we", 32'(bus.mem_we), 32'h0);
      chk("np_wait", 32'(bus.dl_wait), 32'h1);
      chk("np_rd_addr", 32'(bus.mem_addr), 32'h60);
      bus.mem_ack = 1'b1; bus.mem_dout = 8'h12;
      tick();
      bus.mem_ack = 1'b0;
      chk("np_cas_data", 32'(bus.cas_data), 32'h12);
      chk("np_idle_we", 32'(bus.mem_we), 32'h0);
      tick();
      chk("np_we", 32'(bus.mem_we), 32'h1);
      chk("np_w_addr", 32'(bus.mem_addr), 32'h40);
      chk("np_w_din", 32'(bus.mem_din), 32'h99);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("np_we_off", 32'(bus.mem_we), 32'h0);
      $display("txn read addr=60 then pending write addr=40 done");

      // Overflowing the download buffer
      base_w = wr_cnt;
      chk("ov_err_before", 32'(bus.err), 32'h0);
      bus.dl_wr = 1'b1; bus.dl_addr = 25'h30; bus.dl_data = 8'h11;
      tick();
      bus.dl_addr = 25'h31; bus.dl_data = 8'h22;
      tick();
      bus.dl_wr = 1'b0;
      chk("ov_err", 32'(bus.err), 32'h1);
      chk("ov_addr", 32'(bus.mem_addr), 32'h30);
      chk("ov_din", 32'(bus.mem_din), 32'h11);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("ov_wait_off", 32'(bus.dl_wait), 32'h0);
      repeat (3) tick();
      chk("ov_no_second", 32'(bus.mem_we), 32'h0);
      chk("ov_one_write", 32'(wr_cnt - base_w), 32'h1);
      chk("ov_err_sticky", 32'(bus.err), 32'h1);
      $display("txn overflow write addr=30 din=11 done");

      // Reset in the middle of a read
      base_v = valid_cnt;
      bus.cas_rd = 1'b1; bus.cas_addr = 25'h55;
      tick();
      bus.cas_rd = 1'b0;
      tick();
      chk("rr_rd", 32'(bus.mem_rd), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rr_rd_off", 32'(bus.mem_rd), 32'h0);
      chk("rr_err_clr", 32'(bus.err), 32'h0);
      bus.mem_ack = 1'b1; bus.mem_dout = 8'h5A;
      tick();
      bus.mem_ack = 1'b0;
      chk("rr_no_valid", 32'(valid_cnt - base_v), 32'h0);
      chk("rr_cas_data", 32'(bus.cas_data), 32'h0);
      chk("rr_rd_idle", 32'(bus.mem_rd), 32'h0);
      bus.dl_wr = 1'b1; bus.dl_addr = 25'h01; bus.dl_data = 8'h02;
      tick();
      bus.dl_wr = 1'b0;
      chk("rr_idle_write", 32'(bus.mem_we), 32'h1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      $display("txn reset during read done");

      // cas_rd held high through reset must not start a read
      reset = 1'b1; bus.cas_rd = 1'b1; bus.cas_addr = 25'h66;
      tick();
      tick();
      reset = 1'b0;
      repeat (4) tick();
      chk("hold_no_rd", 32'(bus.mem_rd), 32'h0);
      bus.cas_rd = 1'b0;
      tick();
      $display("txn cas_rd held through reset done");

`ifdef CAS_ARB_TIMEOUT_EN
      begin
         int cnt;
         cnt = 0;
         bus.cas_rd = 1'b1; bus.cas_addr = 25'h70;
         tick();
         bus.cas_rd = 1'b0;
         tick();
         while (bus.mem_rd && cnt < 300) begin
            cnt++;
            tick();
         end
         chk("to_cycles", 32'(cnt), 32'd255);
         chk("to_cas_data", 32'(bus.cas_data), 32'hFF);
         chk("to_valid", 32'(bus.cas_valid), 32'h1);
         chk("to_err", 32'(bus.err), 32'h1);
         $display("txn read timeout after %0d cycles", cnt);
      end
`endif

      chk("no_we_rd_overlap", 32'(overlap_cnt), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
